// File: rtl/bin2bcd_pkg.sv
// Shared constants and types for the bin2BCD conversion path.
// The digit count is derived from the magnitude width so the two cannot drift apart.
package bin2bcd_pkg;

  // Number of decimal digits needed to hold 2**w - 1.
  function automatic int digits_for(input int w);
    longint v;
    int     n;
    v = (64'd1 << w) - 64'd1;
    n = 1;
    for (int i = 0; i < 20; i++) begin
      if (v >= 10) begin
        v = v / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int BIN_W    = 10;
  localparam int DIGITS   = digits_for(BIN_W);
  localparam int BCD_W    = 4 * DIGITS;
  localparam int SIGN_BIT = BCD_W;
  localparam int CNT_W    = $clog2(BIN_W + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that
// the following left shift carries cleanly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_shift_add.sv
// Iterative shift-and-add-3 converter: one magnitude bit per clock, signed
// packed BCD result with a single-cycle valid pulse on completion.
module bcd_shift_add
  import bin2bcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bin_vld_pre,
  input  logic [BIN_W-1:0]  bin_reg_pre,
  input  logic [BCD_W:0]    bcd_reg_pre,
  output logic              busy,
  output logic [BCD_W:0]    bcd,
  output logic              bcd_vld,
  output logic              ovr
);

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [BIN_W-1:0]        bin_shift_reg, bin_shift_next;
  logic [BCD_W-1:0]        bcd_work_reg, bcd_work_next;
  logic                    sign_reg, sign_next;
  logic [BCD_W:0]          bcd_reg, bcd_next;
  logic                    bcd_vld_reg, bcd_vld_next;
  logic                    ovr_reg, ovr_next;

  logic [BCD_W-1:0]        corrected;
  logic [BCD_W+BIN_W-1:0]  shifted;

  // All digits are corrected in parallel from the pre-iteration value.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_work_reg[4*gi +: 4]),
      .dout (corrected[4*gi +: 4])
    );
  end

  // The top digit's carry-out is always 0 for in-range magnitudes and falls off here.
  assign shifted = {corrected, bin_shift_reg} << 1;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bin_shift_next = bin_shift_reg;
    bcd_work_next  = bcd_work_reg;
    sign_next      = sign_reg;
    bcd_next       = bcd_reg;
    bcd_vld_next   = 1'b0;
    ovr_next       = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (bin_vld_pre) begin
          bin_shift_next = bin_reg_pre;
          bcd_work_next  = bcd_reg_pre[BCD_W-1:0];
          // A zero magnitude never reports a negative sign.
          sign_next      = bcd_reg_pre[SIGN_BIT] & (|bin_reg_pre);
          cnt_next       = '0;
          state_next     = SHIFT;
        end
      end
      SHIFT: begin
        ovr_next       = bin_vld_pre;
        bcd_work_next  = shifted[BCD_W+BIN_W-1:BIN_W];
        bin_shift_next = shifted[BIN_W-1:0];
        cnt_next       = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(BIN_W - 1)) begin
          bcd_next     = {sign_reg, shifted[BCD_W+BIN_W-1:BIN_W]};
          bcd_vld_next = 1'b1;
          state_next   = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bin_shift_reg <= '0;
      bcd_work_reg  <= '0;
      sign_reg      <= 1'b0;
      bcd_reg       <= '0;
      bcd_vld_reg   <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bin_shift_reg <= bin_shift_next;
      bcd_work_reg  <= bcd_work_next;
      sign_reg      <= sign_next;
      bcd_reg       <= bcd_next;
      bcd_vld_reg   <= bcd_vld_next;
      ovr_reg       <= ovr_next;
    end
  end

  assign busy    = (state_reg == SHIFT);
  assign bcd     = bcd_reg;
  assign bcd_vld = bcd_vld_reg;
  assign ovr     = ovr_reg;

endmodule

// File: tb/tb_bcd_shift_add.sv
// Directed self-checking bench for bcd_shift_add: reset, conversions,
// full sweep against a decimal reference, overrun and mid-conversion reset.
module tb_bcd_shift_add;

  logic        clk;
  logic        rst_n;
  logic        bin_vld_pre;
  logic [9:0]  bin_reg_pre;
  logic [16:0] bcd_reg_pre;
  logic        busy;
  logic [16:0] bcd;
  logic        bcd_vld;
  logic        ovr;

  int checks;
  int failures;

  bcd_shift_add dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bin_vld_pre (bin_vld_pre),
    .bin_reg_pre (bin_reg_pre),
    .bcd_reg_pre (bcd_reg_pre),
    .busy        (busy),
    .bcd         (bcd),
    .bcd_vld     (bcd_vld),
    .ovr         (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference built with division, independent of the shift algorithm.
  function automatic logic [16:0] ref_bcd(input int m, input bit s);
    return {(s && m != 0), 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Drives one sample and waits (bounded) for the result; lat = -1 on timeout.
  task automatic run_conv(input int m, input logic [16:0] seed,
                          output int lat, output logic [16:0] res);
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'(m);
    bcd_reg_pre = seed;
    tick();
    bin_vld_pre = 1'b0;
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bcd_vld) begin
        lat = i;
        res = bcd;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bin_vld_pre = 1'b0;
    bin_reg_pre = '0;
    bcd_reg_pre = '0;
    #2;
    checks++;
    if ({busy, bcd, bcd_vld, ovr} !== 20'h0) begin
      failures++;
      $display("FAIL reset_async: busy=%b bcd=%h vld=%b ovr=%b, want all 0", busy, bcd, bcd_vld, ovr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, bcd, bcd_vld, ovr} !== 20'h0) begin
      failures++;
      $display("FAIL reset_release: busy=%b bcd=%h vld=%b ovr=%b, want all 0", busy, bcd, bcd_vld, ovr);
    end
    $display("reset: done");
  endtask

  task automatic test_zero();
    int busy_cnt;
    int vld_cnt;
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd0;
    bcd_reg_pre = 17'h00000;
    tick();
    bin_vld_pre = 1'b0;
    busy_cnt = busy ? 1 : 0;
    vld_cnt  = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (bcd_vld) vld_cnt++;
    end
    checks++;
    if (busy_cnt !== 10 || vld_cnt !== 0) begin
      failures++;
      $display("FAIL zero_busy: busy cycles=%0d early vld=%0d, want 10 and 0", busy_cnt, vld_cnt);
    end
    tick();
    checks++;
    if (bcd_vld !== 1'b1 || busy !== 1'b0 || bcd !== 17'h00000) begin
      failures++;
      $display("FAIL zero_result: vld=%b busy=%b bcd=%h, want 1 0 00000", bcd_vld, busy, bcd);
    end
    tick();
    checks++;
    if (bcd_vld !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse: vld=%b one cycle later, want 0", bcd_vld);
    end
    $display("zero: bcd=%h", bcd);
  endtask

  task automatic test_directed();
    int          lat;
    logic [16:0] res;
    int          m_tab[4]    = '{1023, 999, 0, 1};
    logic [16:0] seed_tab[4] = '{17'h00000, 17'h10000, 17'h10000, 17'h10000};
    logic [16:0] exp_tab[4]  = '{17'h01023, 17'h10999, 17'h00000, 17'h10001};
    for (int k = 0; k < 4; k++) begin
      run_conv(m_tab[k], seed_tab[k], lat, res);
      checks++;
      if (lat != 10 || res !== exp_tab[k]) begin
        failures++;
        $display("FAIL directed_%0d: got bcd=%h lat=%0d, want %h lat=10", m_tab[k], res, lat, exp_tab[k]);
      end
      $display("directed: bin=%0d seed=%h bcd=%h lat=%0d", m_tab[k], seed_tab[k], res, lat);
    end
  endtask

  task automatic test_sweep();
    int          lat;
    logic [16:0] res;
    logic [16:0] exp;
    int          bad;
    bad = 0;
    for (int s = 0; s < 2; s++) begin
      for (int m = 0; m < 1024; m++) begin
        run_conv(m, {s[0], 16'h0000}, lat, res);
        exp = ref_bcd(m, s[0]);
        checks++;
        if (lat != 10 || res !== exp) begin
          failures++;
          bad++;
          $display("FAIL sweep_%0d_s%0d: got bcd=%h lat=%0d, want %h lat=10", m, s, res, lat, exp);
        end
      end
    end
    $display("sweep: 2048 conversions, %0d bad", bad);
  endtask

  task automatic test_back_to_back();
    int          vld_cnt;
    int          lat;
    logic [16:0] res;
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd255;
    bcd_reg_pre = 17'h00000;
    tick();                       // E0
    bin_vld_pre = 1'b0;
    tick();                       // E1
    tick();                       // E2
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd100;
    tick();                       // E3: dropped
    bin_vld_pre = 1'b0;
    checks++;
    if (ovr !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_ovr: ovr=%b busy=%b after E3, want 1 1", ovr, busy);
    end
    vld_cnt = 0;
    for (int i = 4; i <= 9; i++) begin
      tick();
      if (bcd_vld) vld_cnt++;
      if (i == 4) begin
        checks++;
        if (ovr !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ovr_pulse: ovr=%b after E4, want 0", ovr);
        end
      end
    end
    tick();                       // E10
    checks++;
    if (vld_cnt != 0 || bcd_vld !== 1'b1 || bcd !== 17'h00255) begin
      failures++;
      $display("FAIL b2b_first: early vld=%0d vld=%b bcd=%h, want 0 1 00255", vld_cnt, bcd_vld, bcd);
    end
    $display("back_to_back: first bcd=%h", bcd);
    run_conv(100, 17'h00000, lat, res);   // captured at E11
    checks++;
    if (lat != 10 || res !== 17'h00100) begin
      failures++;
      $display("FAIL b2b_second: got bcd=%h lat=%0d, want 00100 lat=10", res, lat);
    end
    $display("back_to_back: second bcd=%h lat=%0d", res, lat);
  endtask

  task automatic test_completion_overlap();
    int vld_cnt;
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd7;
    bcd_reg_pre = 17'h00000;
    tick();                       // E0
    bin_vld_pre = 1'b0;
    for (int i = 1; i <= 9; i++) tick();
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd42;
    tick();                       // E10: completion plus dropped sample
    bin_vld_pre = 1'b0;
    checks++;
    if (bcd_vld !== 1'b1 || ovr !== 1'b1 || bcd !== 17'h00007) begin
      failures++;
      $display("FAIL overlap_edge: vld=%b ovr=%b bcd=%h, want 1 1 00007", bcd_vld, ovr, bcd);
    end
    vld_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bcd_vld) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0 || busy !== 1'b0 || bcd !== 17'h00007) begin
      failures++;
      $display("FAIL overlap_drop: extra vld=%0d busy=%b bcd=%h, want 0 0 00007", vld_cnt, busy, bcd);
    end
    $display("overlap: bcd=%h held, extra vld=%0d", bcd, vld_cnt);
  endtask

  task automatic test_reset_mid();
    int          vld_cnt;
    int          lat;
    logic [16:0] res;
    bin_vld_pre = 1'b1;
    bin_reg_pre = 10'd512;
    bcd_reg_pre = 17'h00000;
    tick();                       // E0
    bin_vld_pre = 1'b0;
    for (int i = 1; i <= 4; i++) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, bcd, bcd_vld, ovr} !== 20'h0) begin
      failures++;
      $display("FAIL midreset_async: busy=%b bcd=%h vld=%b ovr=%b, want all 0", busy, bcd, bcd_vld, ovr);
    end
    tick();
    tick();
    rst_n = 1'b1;
    vld_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bcd_vld) vld_cnt++;
    end
    checks++;
    if (vld_cnt != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_abort: vld pulses=%0d busy=%b, want 0 0", vld_cnt, busy);
    end
    run_conv(512, 17'h00000, lat, res);
    checks++;
    if (lat != 10 || res !== 17'h00512) begin
      failures++;
      $display("FAIL midreset_recover: got bcd=%h lat=%0d, want 00512 lat=10", res, lat);
    end
    $display("reset_mid: recover bcd=%h lat=%0d", res, lat);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_zero();
    test_directed();
    test_back_to_back();
    test_completion_overlap();
    test_reset_mid();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
